// File: rtl/outlier_pkg.sv
// outlier_pkg: shared types and constants for the streaming outlier segment
package outlier_pkg;
  typedef logic [15:0] fp16_t;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [2:0] RND_RNE = 3'b000;
  localparam int ST_INVALID = 2;
  localparam int ST_HUGE = 4;
  localparam int ST_INEXACT = 5;
endpackage

// File: rtl/outlier_fp_mult.sv
// outlier_fp_mult: DW_fp_mult-compatible IEEE multiplier (a, b, rnd -> z, status)
module outlier_fp_mult #(
  parameter int SIG_W = 10,
  parameter int EXP_W = 5,
  parameter int IEEE_COMPL = 1
) (
  input  logic [SIG_W+EXP_W:0] a,
  input  logic [SIG_W+EXP_W:0] b,
  input  logic [2:0]           rnd,
  output logic [SIG_W+EXP_W:0] z,
  output logic [7:0]           status
);
  localparam int W = SIG_W + EXP_W + 1;
  localparam int P_W = 2 * SIG_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  logic sa, sb, sn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st, inc;
  logic [EXP_W-1:0] ea, eb;
  logic [SIG_W-1:0] fa, fb;
  logic [SIG_W:0] ma, mb, mant;
  logic [P_W-1:0] p;
  logic [63:0] q, sum;
  int xa, xb, l, e, r, ef;
  always_comb begin
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    sn = sa ^ sb;
    a_nan = &ea && |fa;
    b_nan = &eb && |fb;
    a_inf = &ea && ~|fa;
    b_inf = &eb && ~|fb;
    a_zero = ~|ea && (~|fa || IEEE_COMPL == 0);
    b_zero = ~|eb && (~|fb || IEEE_COMPL == 0);
    ma = {|ea, fa};
    mb = {|eb, fb};
    xa = |ea ? int'(ea) : 1;
    xb = |eb ? int'(eb) : 1;
    p = ma * mb;
    l = 0;
    for (int i = 0; i < P_W; i++) if (p[i]) l = i;
    // e is the biased result exponent; below 1 the shift grows to denormalise
    e = l + xa + xb - BIAS - 2 * SIG_W;
    r = e >= 1 ? l + 3 : l + 4 - e;
    if (r > 63) r = 63;
    q = 64'(p) << (SIG_W + 3);
    mant = (SIG_W + 1)'(q >> r);
    g = q[r-1];
    st = |(q & ((64'd1 << (r - 1)) - 64'd1));
    inc = rnd != 3'b001 && g && (st || mant[0]);
    ef = e >= 1 ? e - 1 : 0;
    sum = (64'(ef) << SIG_W) + 64'(mant) + 64'(inc);
    z = '0;
    status = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      z = {1'b0, {EXP_W{1'b1}}, 1'b1, {(SIG_W-1){1'b0}}};
      status[2] = 1'b1;
    end else if (a_inf || b_inf) begin
      z = {sn, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
      status[1] = 1'b1;
    end else if (a_zero || b_zero) begin
      z = {sn, {(W-1){1'b0}}};
      status[0] = 1'b1;
    end else if (sum >= (64'(EMAX) << SIG_W)) begin
      z = rnd == 3'b001 ? {sn, EXP_W'(EMAX - 1), {SIG_W{1'b1}}} : {sn, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
      status[1] = rnd != 3'b001;
      status[4] = 1'b1;
      status[5] = 1'b1;
    end else if (sum < (64'd1 << SIG_W) && (IEEE_COMPL == 0 || sum == 64'd0)) begin
      z = {sn, {(W-1){1'b0}}};
      status[0] = 1'b1;
      status[3] = 1'b1;
      status[5] = 1'b1;
    end else begin
      z = {sn, sum[W-2:0]};
      status[3] = sum < (64'd1 << SIG_W);
      status[5] = g || st;
    end
  end
endmodule

// File: rtl/outlier_pick.sv
// outlier_pick: cascaded find-first-set picking the NUM_LR lowest set mask bits
module outlier_pick #(
  parameter int DIMM = 64,
  parameter int NUM_LR = 4,
  parameter int IDX_W = $clog2(DIMM)
) (
  input  logic [DIMM-1:0]               mask,
  output logic [NUM_LR-1:0][IDX_W-1:0]  idx,
  output logic [NUM_LR-1:0]             vld,
  output logic [DIMM-1:0]               mask_nxt
);
  logic [DIMM-1:0] m;
  always_comb begin
    m = mask;
    idx = '0;
    vld = '0;
    for (int k = 0; k < NUM_LR; k++) begin
      for (int i = DIMM - 1; i >= 0; i--) begin
        if (m[i]) begin
          idx[k] = IDX_W'(i);
          vld[k] = 1'b1;
        end
      end
      if (vld[k]) m[idx[k]] = 1'b0;
    end
    mask_nxt = m;
  end
endmodule

// File: rtl/outlier_seg_stream.sv
// outlier_seg_stream: streams flagged lanes (lowest index first) as NUM_LR-wide product beats.
// Define OUTLIER_STATUS_EN to expose per-slot multiplier status and an exception summary.
module outlier_seg_stream
  import outlier_pkg::*;
#(
  parameter int DIMM = 64,
  parameter int NUM_LR = 4,
  parameter int IDX_W = $clog2(DIMM),
  parameter int BEAT_W = $clog2((DIMM + NUM_LR - 1) / NUM_LR) + 1,
  parameter int SIG_W = 10,
  parameter int EXP_W = 5,
  parameter int IEEE_COMPL = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIMM-1:0]               in_overflow,
  input  fp16_t [DIMM-1:0]              in_a,
  input  fp16_t [DIMM-1:0]              in_w,
  output logic                          out_valid,
  input  logic                          out_ready,
  output fp16_t [NUM_LR-1:0]            out_prod,
  output logic [NUM_LR-1:0][IDX_W-1:0]  out_index,
  output logic [NUM_LR-1:0]             out_lane_vld,
  output logic                          out_last,
`ifdef OUTLIER_STATUS_EN
  output logic [NUM_LR-1:0][7:0]        out_status,
  output logic                          out_any_exc,
`endif
  output logic [BEAT_W-1:0]             out_beat
);
  state_t state, state_nxt;
  fp16_t [DIMM-1:0] a_r, w_r;
  logic [DIMM-1:0] mask_r, mask_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [NUM_LR-1:0][IDX_W-1:0] pick_idx;
  logic [NUM_LR-1:0] pick_vld;
  fp16_t [NUM_LR-1:0] prod;
  logic load;
  assign in_ready = state == IDLE;
  // the output register may only advance when empty or being drained
  assign load = state == SCAN && (!out_valid || out_ready);
  always_comb state_nxt = state == IDLE ? (in_valid ? SCAN : IDLE) : (load && ~|mask_nxt ? IDLE : SCAN);
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  outlier_pick #(.DIMM(DIMM), .NUM_LR(NUM_LR), .IDX_W(IDX_W)) u_pick (
    .mask(mask_r), .idx(pick_idx), .vld(pick_vld), .mask_nxt(mask_nxt)
  );
`ifdef OUTLIER_STATUS_EN
  logic [NUM_LR-1:0][7:0] stat;
`endif
  for (genvar k = 0; k < NUM_LR; k++) begin : g_mul
    outlier_fp_mult #(.SIG_W(SIG_W), .EXP_W(EXP_W), .IEEE_COMPL(IEEE_COMPL)) u_mul (
      .a(a_r[pick_idx[k]]), .b(w_r[pick_idx[k]]), .rnd(RND_RNE), .z(prod[k]),
`ifdef OUTLIER_STATUS_EN
      .status(stat[k])
`else
      .status()
`endif
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      w_r <= '0;
      mask_r <= '0;
      beat_cnt <= '0;
      out_valid <= 1'b0;
      out_prod <= '0;
      out_index <= '0;
      out_lane_vld <= '0;
      out_last <= 1'b0;
      out_beat <= '0;
    end else begin
      if (in_valid && in_ready) begin
        a_r <= in_a;
        w_r <= in_w;
        mask_r <= in_overflow;
        beat_cnt <= '0;
      end
      if (load) begin
        mask_r <= mask_nxt;
        beat_cnt <= beat_cnt + BEAT_W'(1);
        out_beat <= beat_cnt;
        out_last <= ~|mask_nxt;
        out_valid <= 1'b1;
        out_index <= pick_idx;
        out_lane_vld <= pick_vld;
        for (int k = 0; k < NUM_LR; k++) out_prod[k] <= pick_vld[k] ? prod[k] : '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
`ifdef OUTLIER_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) out_status <= '0;
    else if (load) for (int k = 0; k < NUM_LR; k++) out_status[k] <= pick_vld[k] ? stat[k] : 8'd0;
  end
  always_comb begin
    out_any_exc = 1'b0;
    for (int k = 0; k < NUM_LR; k++)
      out_any_exc |= out_lane_vld[k] && (out_status[k][ST_INEXACT] || out_status[k][ST_HUGE] || out_status[k][ST_INVALID]);
  end
`endif
endmodule

// File: tb/tb_outlier_seg_stream.sv
// tb_outlier_seg_stream: directed scoreboard bench for the streaming outlier segment
module tb_outlier_seg_stream;
  localparam int DIMM = 8;
  localparam int NUM_LR = 4;
  typedef struct {
    logic [63:0] prod;
    logic [11:0] idx;
    logic [3:0]  vld;
    logic        last;
    logic [1:0]  beat;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_last;
  logic [7:0] in_overflow = '0;
  logic [7:0][15:0] in_a = '0;
  logic [7:0][15:0] in_w = '0;
  logic [3:0][15:0] out_prod;
  logic [3:0][2:0] out_index;
  logic [3:0] out_lane_vld;
  logic [1:0] out_beat;
  beat_t exp_q[$];
  int n_assert = 0;
  int n_fail = 0;
  // a[i] = 1.0 + i and the exact products a[i] * 2.0
  logic [15:0] a_tab [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
  logic [15:0] p2_tab[8] = '{16'h4000, 16'h4400, 16'h4600, 16'h4800, 16'h4900, 16'h4A00, 16'h4B00, 16'h4C00};

  outlier_seg_stream #(.DIMM(DIMM), .NUM_LR(NUM_LR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_overflow(in_overflow),
    .in_a(in_a), .in_w(in_w), .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .out_index(out_index), .out_lane_vld(out_lane_vld), .out_last(out_last), .out_beat(out_beat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] ov, input bit neg);
    beat_t b;
    int slot = 0;
    int bn = 0;
    b = '{default: '0};
    for (int i = 0; i < 8; i++) begin
      if (ov[i]) begin
        b.prod[slot*16 +: 16] = neg ? (a_tab[i] ^ 16'h8000) : p2_tab[i];
        b.idx[slot*3 +: 3] = 3'(i);
        b.vld[slot] = 1'b1;
        slot++;
        if (slot == 4) begin
          b.beat = 2'(bn);
          b.last = (ov >> (i + 1)) == 0;
          exp_q.push_back(b);
          b = '{default: '0};
          slot = 0;
          bn++;
        end
      end
    end
    if (slot > 0 || ov == 0) begin
      b.beat = 2'(bn);
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic send(input logic [7:0] ov, input bit neg);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_overflow = ov;
    for (int i = 0; i < 8; i++) begin
      in_a[i] = a_tab[i];
      in_w[i] = neg ? 16'hBC00 : 16'h4000;
    end
    push_exp(ov, neg);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_overflow = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      in_a[i] = 16'($urandom);
      in_w[i] = 16'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(exp_q.size()), 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_valid", out_valid, 1);
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("prod", out_prod, e.prod);
        chk("index", out_index, e.idx);
        chk("lane_vld", out_lane_vld, e.vld);
        chk("last", out_last, e.last);
        chk("beat", out_beat, e.beat);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_beat", out_beat, 0);
    chk("rst_lane_vld", out_lane_vld, 0);
    chk("rst_prod", out_prod, 0);
    chk("rst_index", out_index, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    send(8'b1010_0110, 1'b0);
    chk("latency_pre", out_valid, 0);
    @(posedge clk); #1;
    chk("latency_post", out_valid, 1);
    drain();
    chk("idle_valid", out_valid, 0);
    send(8'hFF, 1'b0);
    drain();
    send(8'b0100_0000, 1'b1);
    drain();
    send(8'h00, 1'b0);
    chk("zero_in_ready_busy", in_ready, 0);
    @(posedge clk); #1;
    chk("zero_in_ready_back", in_ready, 1);
    chk("zero_valid", out_valid, 1);
    drain();
    out_ready = 1'b0;
    send(8'hFF, 1'b0);
    wait_valid();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_prod", out_prod, exp_q[0].prod);
      chk("stall_index", out_index, exp_q[0].idx);
      chk("stall_beat", out_beat, 0);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_beat1", out_beat, 1);
    chk("b2b_last", out_last, 1);
    chk("b2b_in_ready", in_ready, 1);
    send(8'h5A, 1'b1);
    chk("b2b_hold_valid", out_valid, 1);
    chk("b2b_hold_index", out_index, exp_q[0].idx);
    chk("b2b_in_ready_busy", in_ready, 0);
    out_ready = 1'b1;
    drain();
    out_ready = 1'b0;
    send(8'hFF, 1'b0);
    wait_valid();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_lane_vld", out_lane_vld, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_prod", out_prod, 0);
    @(posedge clk); #1;
    chk("mid_rst_no_beat", out_valid, 0);
    out_ready = 1'b1;
    send(8'h01, 1'b0);
    drain();
    for (int j = 0; j < 6; j++) send(8'($urandom), j[0]);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end
endmodule
